// File: rtl/define.sv
// Core-wide ALU operation codes; the memory-op subset drives the load/store unit.
package define_pkg;

  localparam int unsigned ALUCODE_W = 6;

  localparam logic [ALUCODE_W-1:0] ALU_ADD = 6'd1;
  localparam logic [ALUCODE_W-1:0] ALU_LB  = 6'd18;
  localparam logic [ALUCODE_W-1:0] ALU_LH  = 6'd19;
  localparam logic [ALUCODE_W-1:0] ALU_LW  = 6'd20;
  localparam logic [ALUCODE_W-1:0] ALU_LBU = 6'd21;
  localparam logic [ALUCODE_W-1:0] ALU_LHU = 6'd22;
  localparam logic [ALUCODE_W-1:0] ALU_SB  = 6'd23;
  localparam logic [ALUCODE_W-1:0] ALU_SH  = 6'd24;
  localparam logic [ALUCODE_W-1:0] ALU_SW  = 6'd25;

endpackage

// File: rtl/lsu_pkg.sv
// Load/store unit types and access-classification helpers.
package lsu_pkg;
  import define_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input logic [ALUCODE_W-1:0] op);
    return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
           (op == ALU_LBU) || (op == ALU_LHU);
  endfunction

  function automatic logic is_store(input logic [ALUCODE_W-1:0] op);
    return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  // Halfword ops need addr[0]==0, word ops need addr[1:0]==0; bytes always fit.
  function automatic logic is_misaligned(input logic [ALUCODE_W-1:0] op,
                                         input logic [1:0] lo);
    logic half_op;
    logic word_op;
    half_op = (op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH);
    word_op = (op == ALU_LW) || (op == ALU_SW);
    return (half_op && lo[0]) || (word_op && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_align
  import define_pkg::*;
  import lsu_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata >> {addr_lo, 3'b000};

  // Store byte enables and replicated write data.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (alucode == ALU_SB) begin
      be    = 4'b0001 << addr_lo;
      wdata = {4{store_data[7:0]}};
    end else if (alucode == ALU_SH) begin
      be    = 4'b0011 << addr_lo;
      wdata = {2{store_data[15:0]}};
    end
  end

  // Load lane select with sign or zero extension.
  always_comb begin
    load_data = rdata;
    case (alucode)
      ALU_LB:  load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      ALU_LBU: load_data = {24'd0, w_shifted[7:0]};
      ALU_LH:  load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      ALU_LHU: load_data = {16'd0, w_shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between execute and writeback.
module lsu
  import define_pkg::*;
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_wb,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        misaligned
);

  lsu_state_t  r_state;
  logic        r_req_ready;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_resp_valid;
  logic        r_resp_wb;
  logic [4:0]  r_resp_rd;
  logic [31:0] r_resp_data;
  logic        r_misaligned;
  logic [5:0]  r_op;
  logic [1:0]  r_lo;

  logic [5:0]  w_op;
  logic [1:0]  w_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_accept;

  // Steering uses live request fields in IDLE and the held op while waiting on memory.
  assign w_op     = (r_state == ST_IDLE) ? alucode : r_op;
  assign w_lo     = (r_state == ST_IDLE) ? addr[1:0] : r_lo;
  assign w_accept = req_valid && r_req_ready;

  lsu_align u_align (
    .alucode    (w_op),
    .addr_lo    (w_lo),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (w_be),
    .wdata      (w_wdata),
    .load_data  (w_load_data)
  );

  // Request/response sequencing: IDLE -> MEM -> RESP, or IDLE -> RESP when misaligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_wb    <= 1'b0;
      r_resp_rd    <= '0;
      r_resp_data  <= '0;
      r_misaligned <= 1'b0;
      r_op         <= '0;
      r_lo         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (is_load(alucode) || is_store(alucode))) begin
            r_req_ready <= 1'b0;
            r_resp_rd   <= rd_in;
            if (is_misaligned(alucode, addr[1:0])) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_wb    <= 1'b0;
              r_resp_data  <= '0;
              r_misaligned <= 1'b1;
            end else begin
              r_state     <= ST_MEM;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store(alucode);
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_op        <= alucode;
              r_lo        <= addr[1:0];
            end
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_state      <= ST_RESP;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_wb    <= is_load(r_op);
            r_resp_data  <= is_load(r_op) ? w_load_data : 32'd0;
            r_misaligned <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_wb    <= 1'b0;
          r_misaligned <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_wb    = r_resp_wb;
  assign resp_rd    = r_resp_rd;
  assign resp_data  = r_resp_data;
  assign misaligned = r_misaligned;

endmodule

// File: doc/lsu.md
Name:
lsu

Overview:
- Load/store unit for the rv32 core. It consumes the memory-op alucode (ALU_LB..ALU_SW from define.sv) and the effective address produced by the ALU's add path.
- It drives a single-outstanding, request/acknowledge data-memory port, handles byte-lane steering and sign/zero extension, and returns load data plus a completion pulse to writeback.
- It sits between execute and writeback and is the consumer of the ALU address result.

Parameters:
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- alucode  in  6  ALU_LB/LH/LW/LBU/LHU/SB/SH/SW
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value, low bits significant for SB/SH
- rd_in  in  5  destination register tag
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  one-cycle completion pulse; mem_rdata valid with it
- mem_rdata  in  32  read word
- resp_valid  out  1  one-cycle completion pulse
- resp_wb  out  1  write resp_data to resp_rd (loads only, not misaligned)
- resp_rd  out  5  tag of the completed request
- resp_data  out  32  extended load data; 0 for stores and misaligned accesses
- misaligned  out  1  qualifies resp_valid; access was not performed

Behaviour:
- Reset: state IDLE. mem_req, mem_we, resp_valid, resp_wb and misaligned are 0. mem_addr, mem_be, mem_wdata, resp_rd and resp_data are 0.
- States: IDLE, MEM, RESP. All outputs are registered.
- Handshake: a request is accepted when req_valid & req_ready.
- Accepted non-memory alucode: dropped with no response; the unit stays in IDLE.
- Alignment check at accept time:
  - LH/LHU/SH are misaligned if addr[0]=1.
  - LW/SW are misaligned if addr[1:0]!=0.
  - Byte ops are never misaligned.
- IDLE, aligned accept -> MEM. mem_req=1 and all request fields are registered in the same edge.
- IDLE, misaligned accept -> RESP with misaligned=1 and resp_wb=0. No memory request is issued.
- MEM:
  - mem_req and all request fields are held stable until mem_ack.
  - On mem_ack: mem_req drops and the state moves to RESP. Load data is captured and extended that same edge.
  - Wait length is unbounded.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in this cycle.
- Minimum latency: accept at T, mem_req at T+1, ack at T+1, resp_valid at T+2. Misaligned: resp_valid at T+1.
- Byte enables:
  - SB: mem_be=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: mem_be=4'b0011<<addr[1:0], wdata={2{store_data[15:0]}}.
  - SW: mem_be=4'b1111.
  - Loads: mem_be=4'b1111, mem_we=0.
- Loads select the byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores complete with resp_valid=1, resp_wb=0, resp_data=0.
- mem_ack outside MEM is ignored.
- Reset mid-operation: mem_req drops the next edge. A late ack after reset is ignored. No resp_valid is emitted for the aborted request.

Decomposition:
- Memory-op alucodes stay in define.sv.
- lsu_pkg holds the state enum (IDLE/MEM/RESP) and the misalignment predicate function.
- Combinational sub-module lsu_align holds store lane steering/be generation and load extraction/extension. It is reused by the bench's reference model.

Test Plan:
- LW addr=0x100 -> mem_req with mem_addr=0x100, be=1111. Ack at next cycle with rdata=0xDEADBEEF -> resp_valid 2 cycles after accept, resp_data=0xDEADBEEF, resp_wb=1, resp_rd=rd_in.
- LB addr=0x103 with rdata=0x80FF1234 -> resp_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr=0x102 -> 0xFFFF80FF.
- SB addr=0x201, store_data=0x000000A5 -> be=0010, wdata=0xA5A5A5A5, mem_we=1. SH addr=0x202 -> be=1100. Each completes with resp_wb=0.
- LW addr=0x101 -> no mem_req, resp_valid at T+1 with misaligned=1, resp_wb=0. SH addr=0x203 -> same behaviour.
- Ack delayed 5 cycles -> mem_req and fields stay stable throughout, req_ready=0, and a second req_valid is not accepted until IDLE.
- rst asserted while in MEM -> mem_req=0 the next cycle. A stray ack is ignored. The next LW proceeds normally.
